// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N one-hot decoder.
package decoder_pkg;

    typedef enum logic [1:0] {IDLE, SCAN_EMIT, SCAN_GAP} state_t;

    localparam int MAX_OUT_W = 256;

    function automatic int out_w(input int sel_w);
        return 1 << sel_w;
    endfunction

    // Indices at or beyond width yield an all-zero word.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [7:0] sel, input int width);
        logic [MAX_OUT_W-1:0] word;
        word = '0;
        if (int'(sel) < width) word[sel] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W-to-2^SEL_W one-hot core with enable.
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter  int SEL_W = 3,
    localparam int OUT_W = out_w(SEL_W)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] dout
);

    assign dout = en ? OUT_W'(onehot(8'(sel), OUT_W)) : '0;

endmodule

// File: rtl/decoder_nto2n_reg.sv
// Registered one-hot decoder with valid/ready handshake.
// Optional auto-scan sequencer enabled by defining DECODER_NTO2N_SCAN_EN.
module decoder_nto2n_reg
    import decoder_pkg::*;
#(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = out_w(SEL_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   dout,
    input  logic               scan_start,
    input  logic [DWELL_W-1:0] scan_dwell,
    output logic               scan_busy,
    output logic               scan_done
);

    logic             free;
    logic             load;
    logic [OUT_W-1:0] load_word;
    logic [OUT_W-1:0] dir_word;

    assign free = !out_valid || out_ready;

    decoder_onehot #(.SEL_W(SEL_W)) u_dir (
        .sel  (sel),
        .en   (en),
        .dout (dir_word)
    );

`ifdef DECODER_NTO2N_SCAN_EN
    state_t             state, state_nx;
    logic [SEL_W-1:0]   idx, idx_nx;
    logic [DWELL_W-1:0] dwell, dwell_nx;
    logic [DWELL_W-1:0] gap_cnt, gap_nx;
    logic               last_ld, last_nx;
    logic               done_nx;
    logic               scan_ld;
    logic [OUT_W-1:0]   scan_word;

    decoder_onehot #(.SEL_W(SEL_W)) u_scan (
        .sel  (idx),
        .en   (1'b1),
        .dout (scan_word)
    );

    assign in_ready  = (state == IDLE) && free && !scan_start;
    assign scan_busy = (state != IDLE);
    assign load      = (in_valid && in_ready) || scan_ld;
    assign load_word = scan_ld ? scan_word : dir_word;

    // last_ld marks that the final beat is loaded and only its handshake remains.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        dwell_nx = dwell;
        gap_nx   = gap_cnt;
        last_nx  = last_ld;
        done_nx  = 1'b0;
        scan_ld  = 1'b0;
        case (state)
            IDLE: begin
                if (scan_start) begin
                    state_nx = SCAN_EMIT;
                    dwell_nx = scan_dwell;
                    idx_nx   = '0;
                    last_nx  = 1'b0;
                end
            end
            SCAN_EMIT: begin
                if (last_ld) begin
                    if (out_valid && out_ready) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                        last_nx  = 1'b0;
                        idx_nx   = '0;
                    end
                end else if (free) begin
                    scan_ld = 1'b1;
                    if (&idx) begin
                        last_nx = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                        if (dwell != '0) begin
                            state_nx = SCAN_GAP;
                            gap_nx   = dwell;
                        end
                    end
                end
            end
            SCAN_GAP: begin
                gap_nx = gap_cnt - 1'b1;
                if (gap_cnt <= 1) state_nx = SCAN_EMIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            dwell     <= '0;
            gap_cnt   <= '0;
            last_ld   <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            dwell     <= dwell_nx;
            gap_cnt   <= gap_nx;
            last_ld   <= last_nx;
            scan_done <= done_nx;
        end
    end
`else
    logic scan_unused;

    assign scan_unused = ^{scan_start, scan_dwell};
    assign in_ready    = free;
    assign load        = in_valid && in_ready;
    assign load_word   = dir_word;
    assign scan_busy   = 1'b0;
    assign scan_done   = 1'b0;
`endif

    // dout keeps its last value once drained; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            dout      <= load_word;
            out_valid <= 1'b1;
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// Self-checking bench for decoder_nto2n_reg (SEL_W=3); scan scenarios follow DECODER_NTO2N_SCAN_EN.
module tb_decoder_nto2n_reg;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;
    localparam int OUT_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [SEL_W-1:0]   sel = '0;
    logic               en = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_W-1:0]   dout;
    logic               scan_start = 1'b0;
    logic [DWELL_W-1:0] scan_dwell = '0;
    logic               scan_busy;
    logic               scan_done;

    int nchk = 0;
    int nerr = 0;

    decoder_nto2n_reg #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .en         (en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .scan_start (scan_start),
        .scan_dwell (scan_dwell),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic drive(input logic iv, input logic [2:0] s, input logic e,
                         input logic ordy, input logic ss, input logic [7:0] sd);
        in_valid   = iv;
        sel        = s;
        en         = e;
        out_ready  = ordy;
        scan_start = ss;
        scan_dwell = sd;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #20;
        nchk++; if (dout !== 8'h00) begin nerr++; $display("FAIL reset_dout: got %h expected 00", dout); end
        nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        nchk++; if (scan_busy !== 1'b0) begin nerr++; $display("FAIL reset_scan_busy: got %b expected 0", scan_busy); end
        nchk++; if (scan_done !== 1'b0) begin nerr++; $display("FAIL reset_scan_done: got %b expected 0", scan_done); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1, 3'd5, 1, 1, 0, 0);
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready0: got %b expected 1", in_ready); end
        tick();
        nchk++; if (out_valid !== 1'b1 || dout !== 8'h20) begin nerr++; $display("FAIL b2b_beat0: got v=%b d=%h expected v=1 d=20", out_valid, dout); end
        drive(1, 3'd2, 1, 1, 0, 0);
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready1: got %b expected 1", in_ready); end
        tick();
        nchk++; if (out_valid !== 1'b1 || dout !== 8'h04) begin nerr++; $display("FAIL b2b_beat1: got v=%b d=%h expected v=1 d=04", out_valid, dout); end
        drive(0, 0, 0, 1, 0, 0);
        tick();
        nchk++; if (out_valid !== 1'b0 || dout !== 8'h04) begin nerr++; $display("FAIL b2b_drain: got v=%b d=%h expected v=0 d=04", out_valid, dout); end
    endtask

    task automatic test_backpressure_enable();
        drive(1, 3'd7, 1, 0, 0, 0);
        tick();
        nchk++; if (out_valid !== 1'b1 || dout !== 8'h80) begin nerr++; $display("FAIL bp_load: got v=%b d=%h expected v=1 d=80", out_valid, dout); end
        drive(1, 3'd3, 0, 0, 0, 0);
        nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready: got %b expected 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            nchk++; if (out_valid !== 1'b1 || dout !== 8'h80) begin nerr++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=80", out_valid, dout); end
        end
        drive(1, 3'd3, 0, 1, 0, 0);
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        tick();
        nchk++; if (out_valid !== 1'b1 || dout !== 8'h00) begin nerr++; $display("FAIL en_zero: got v=%b d=%h expected v=1 d=00", out_valid, dout); end
        drive(0, 0, 0, 1, 0, 0);
        tick();
    endtask

    // Reference: a one-deep queue; handshake pops, accept pushes the decoded word.
    task automatic test_random_direct();
        logic [7:0] q[$];
        logic       iv, e, ordy, exp_rdy;
        logic [2:0] s;
        for (int c = 0; c < 300; c++) begin
            iv   = 1'($urandom_range(0, 1));
            e    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            s    = 3'($urandom_range(0, 7));
            drive(iv, s, e, ordy, 0, 0);
            exp_rdy = (q.size() == 0) || ordy;
            nchk++; if (in_ready !== exp_rdy) begin nerr++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, exp_rdy); end
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (iv && exp_rdy) q.push_back(e ? (8'd1 << s) : 8'd0);
            tick();
            nchk++; if (out_valid !== (q.size() != 0)) begin nerr++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                nchk++; if (dout !== q[0]) begin nerr++; $display("FAIL rnd_dout c=%0d: got %h expected %h", c, dout, q[0]); end
            end
        end
        drive(0, 0, 0, 1, 0, 0);
        tick();
    endtask

`ifdef DECODER_NTO2N_SCAN_EN
    // Beat k appears at cycle 1+k*(d+1) after the start edge; done one cycle after the last.
    task automatic scan_run(input int d);
        int  done_n;
        bit  ev;
        int  k;
        done_n = 2 + 7 * (d + 1);
        drive(0, 0, 0, 1, 1, 8'(d));
        nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL scan_start_ready d=%0d: got %b expected 0", d, in_ready); end
        tick();
        drive(0, 0, 0, 1, 0, 0);
        for (int n = 0; n <= done_n + 2; n++) begin
            ev = (n >= 1) && ((n - 1) % (d + 1) == 0) && ((n - 1) / (d + 1) < 8);
            k  = (n >= 1) ? (n - 1) / (d + 1) : 0;
            nchk++; if (out_valid !== ev) begin nerr++; $display("FAIL scan_valid d=%0d n=%0d: got %b expected %b", d, n, out_valid, ev); end
            if (ev) begin
                nchk++; if (dout !== 8'(1 << k)) begin nerr++; $display("FAIL scan_dout d=%0d n=%0d: got %h expected %h", d, n, dout, 8'(1 << k)); end
            end
            nchk++; if (scan_done !== (n == done_n)) begin nerr++; $display("FAIL scan_done d=%0d n=%0d: got %b expected %b", d, n, scan_done, n == done_n); end
            nchk++; if (scan_busy !== (n < done_n)) begin nerr++; $display("FAIL scan_busy d=%0d n=%0d: got %b expected %b", d, n, scan_busy, n < done_n); end
            tick();
        end
    endtask

    task automatic test_scan_dwell();
        scan_run(2);
        scan_run(0);
        scan_run(int'($urandom_range(1, 4)));
    endtask

    task automatic test_scan_conflicts();
        int seen, ndone;
        bit stalled;
        seen = 0; ndone = 0; stalled = 0;
        drive(1, 3'd1, 1, 1, 1, 8'd1);
        nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL conf_ready_start: got %b expected 0", in_ready); end
        tick();
        nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL conf_no_accept: got %b expected 0", out_valid); end
        drive(1, 3'd6, 1, 1, 1, 8'd0);
        nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL conf_ready_busy: got %b expected 0", in_ready); end
        tick();
        for (int c = 0; c < 80 && ndone == 0; c++) begin
            drive(0, 0, 0, 1, 0, 0);
            if (!stalled && out_valid && dout == 8'h10) begin
                stalled = 1;
                out_ready = 1'b0;
                #1;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    drive(0, 0, 0, 0, 0, 0);
                    nchk++; if (out_valid !== 1'b1 || dout !== 8'h10) begin nerr++; $display("FAIL conf_stall_hold s=%0d: got v=%b d=%h expected v=1 d=10", s, out_valid, dout); end
                    nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL conf_stall_ready: got %b expected 0", in_ready); end
                end
                drive(0, 0, 0, 1, 0, 0);
            end
            if (scan_done) ndone++;
            if (out_valid) begin
                nchk++; if (dout !== 8'(1 << seen)) begin nerr++; $display("FAIL conf_seq beat=%0d: got %h expected %h", seen, dout, 8'(1 << seen)); end
                seen++;
            end
            tick();
        end
        nchk++; if (seen != 8) begin nerr++; $display("FAIL conf_beats: got %0d expected 8", seen); end
        nchk++; if (ndone != 1) begin nerr++; $display("FAIL conf_done: got %0d expected 1", ndone); end
        nchk++; if (stalled != 1) begin nerr++; $display("FAIL conf_stalled: got %0d expected 1", stalled); end
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 1, 0, 0);
            nchk++; if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin nerr++; $display("FAIL conf_after: got busy=%b done=%b expected 0 0", scan_busy, scan_done); end
            tick();
        end
    endtask

    task automatic test_abort();
        bit found;
        found = 0;
        drive(0, 0, 0, 1, 1, 8'd0);
        tick();
        for (int c = 0; c < 40 && !found; c++) begin
            drive(0, 0, 0, 1, 0, 0);
            if (out_valid && dout == 8'h40) found = 1;
            else tick();
        end
        nchk++; if (!found) begin nerr++; $display("FAIL abort_reach_idx6: got 0 expected 1"); end
        rst_n = 1'b0;
        #1;
        nchk++; if (dout !== 8'h00 || out_valid !== 1'b0) begin nerr++; $display("FAIL abort_out: got v=%b d=%h expected v=0 d=00", out_valid, dout); end
        nchk++; if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin nerr++; $display("FAIL abort_scan: got busy=%b done=%b expected 0 0", scan_busy, scan_done); end
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL abort_ready: got %b expected 1", in_ready); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            drive(0, 0, 0, 1, 0, 0);
            nchk++; if (scan_done !== 1'b0 || scan_busy !== 1'b0 || out_valid !== 1'b0) begin nerr++; $display("FAIL abort_after c=%0d: got done=%b busy=%b v=%b expected 0 0 0", c, scan_done, scan_busy, out_valid); end
        end
    endtask
`else
    task automatic test_scan_disabled();
        drive(0, 0, 0, 1, 1, 8'd0);
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL noscan_ready: got %b expected 1", in_ready); end
        for (int c = 0; c < 20; c++) begin
            tick();
            drive(0, 0, 0, 1, 0, 0);
            nchk++; if (out_valid !== 1'b0 || scan_busy !== 1'b0 || scan_done !== 1'b0) begin nerr++; $display("FAIL noscan_idle c=%0d: got v=%b busy=%b done=%b expected 0 0 0", c, out_valid, scan_busy, scan_done); end
        end
        drive(1, 3'd4, 1, 1, 1, 8'd0);
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL noscan_ready_req: got %b expected 1", in_ready); end
        tick();
        nchk++; if (out_valid !== 1'b1 || dout !== 8'h10) begin nerr++; $display("FAIL noscan_accept: got v=%b d=%h expected v=1 d=10", out_valid, dout); end
        drive(0, 0, 0, 1, 0, 0);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure_enable();
        test_random_direct();
`ifdef DECODER_NTO2N_SCAN_EN
        test_scan_dwell();
        test_scan_conflicts();
        test_abort();
`else
        test_scan_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/decoder_nto2n_reg.md
# decoder_nto2n_reg

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready handshake and an optional auto-scan sequencer. It generalises the fixed 3-to-8 combinational decoder to any select width. It also adds an enable, output backpressure, and a hardware mode that walks every output in turn. It sits between a select producer, such as a command decoder or bus address stage, and a bank of one-hot consumers: chip-selects, LED or row drivers, or mux enables.

## Interface
Parameters:
- SEL_W, 3: select width. Output width is 2**SEL_W. Legal range is 1..8.
- DWELL_W, 8: width of the scan gap counter.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  the sel/en request is valid.
- in_ready  out  1  the block accepts a request this cycle.
- sel  in  SEL_W  output index to assert.
- en  in  1  when 0, the accepted beat drives all-zero.
- out_valid  out  1  dout holds an unconsumed beat.
- out_ready  in  1  the consumer takes dout this cycle.
- dout  out  2**SEL_W  one-hot (or zero) output word.
- scan_start  in  1  one-cycle pulse that starts an auto-scan.
- scan_dwell  in  DWELL_W  idle cycles between scan beats. Sampled at scan start.
- scan_busy  out  1  a scan is in progress.
- scan_done  out  1  one-cycle pulse after the last scan beat is accepted.

## Operation
- **Output register.** The output register is one entry deep. It is free when out_valid=0 or out_ready=1.
- **Direct mode (state IDLE).**
  - in_ready = free AND NOT scan_start.
  - A request is accepted when in_valid and in_ready are both high.
  - On accept: dout <= en ? (1 << sel) : 0, and out_valid <= 1.
  - When the register is free and no new beat loads, out_valid <= 0. dout holds its last value.
- **Scan mode.** Controlled by an FSM with states IDLE, SCAN_EMIT and SCAN_GAP.
  - IDLE -> SCAN_EMIT when scan_start=1. Capture scan_dwell, set idx=0, and set scan_busy=1. Any in_valid present in that cycle is not accepted.
  - SCAN_EMIT:
    - When the register is free, load dout <= 1 << idx and out_valid <= 1.
    - If idx = 2**SEL_W-1, wait for that beat to be accepted. Then go to IDLE, pulse scan_done and clear scan_busy.
    - Otherwise, increment idx. Go to SCAN_GAP if the captured dwell is greater than 0; otherwise stay in SCAN_EMIT.
  - SCAN_GAP: count the captured dwell value down in cycles, then return to SCAN_EMIT.
  - in_ready is 0 in every state other than IDLE.
  - en is ignored during a scan.
- **Boundary conditions.**
  - scan_start while scan_busy=1 is ignored.
  - scan_start and in_valid in the same IDLE cycle: the scan wins.
  - sel out of range cannot occur, because sel always addresses 2**SEL_W outputs.
  - Reset asserted mid-scan aborts the scan immediately, with no scan_done pulse.
  - out_ready held low stalls the scan in SCAN_EMIT indefinitely with dout stable. idx does not advance.

## Timing
- **Reset values:** dout=0, out_valid=0, in_ready=1 (combinational from free), scan_busy=0, scan_done=0, state=IDLE, idx=0, gap counter=0.
- **Direct-mode latency:** 1 cycle from accept to out_valid.
- **Direct-mode throughput:** 1 beat per cycle when out_ready stays high.
- **Scan timing:**
  - The first beat appears 2 cycles after the scan_start edge: one cycle to enter SCAN_EMIT, one to load.
  - With dwell D and out_ready high, beats are spaced D+1 cycles apart.
  - scan_done asserts the cycle after the final handshake.
- **Stability rule:** dout and out_valid are stable while out_valid=1 and out_ready=0.
- **Paths:** in_ready is the only combinational output path, from out_ready and scan_start.

## Configuration
- **Macro:** DECODER_NTO2N_SCAN_EN.
- **Defined:** the scan FSM, idx and gap counter are built as described above.
- **Undefined:** the ports remain. scan_start and scan_dwell are ignored, scan_busy and scan_done are tied to 0, and the block is direct mode only with in_ready = free.

## Structure
- **Shared package decoder_pkg:**
  - the state enum (IDLE, SCAN_EMIT, SCAN_GAP);
  - the function onehot(sel, width);
  - the localparam OUT_W = 2**SEL_W, given as a helper macro or function of SEL_W.
- **Sub-module decoder_onehot:** a combinational SEL_W-to-OUT_W core with an enable. It is instantiated twice, once for sel and once for idx, or once behind a mux.
- **Top level:** owns the handshake register and the FSM.

## Test plan
All scenarios use SEL_W=3.
- **Reset:** reset with rst_n=0, then release -> dout=8'h00, out_valid=0, in_ready=1, scan_busy=0.
- **Direct back-to-back:** sel=5 then sel=2 with en=1, in_valid high for 2 cycles and out_ready=1 -> dout=8'h20 then 8'h04, each 1 cycle after accept.
- **Backpressure and enable:** with out_ready=0, accept sel=7 -> dout=8'h80 held and in_ready=0. Then out_ready=1 with en=0, sel=3 -> the next beat is 8'h00 with out_valid=1.
- **Scan with dwell:** scan_start with scan_dwell=2 and out_ready=1 -> dout=01,02,04,...,80, spaced 3 cycles apart. scan_done pulses once and scan_busy clears.
- **Scan conflicts:** scan_start together with in_valid; then a second scan_start while busy -> the request is not accepted and the second start is ignored. Then out_ready=0 mid-scan at idx=4 -> dout=8'h10 is held until ready.
- **Abort and configuration:** reset mid-scan at idx=6 -> outputs return to reset values with no scan_done. A build without DECODER_NTO2N_SCAN_EN -> scan_start produces no beats and scan_busy stays 0.
